muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide unit for the RISC-V didactic core, the sequential companion of the single-cycle `alu`. It executes the eight M-extension operations over a parametrised operand width. Execution is radix-2, one bit per clock, with a start/busy/done handshake. The execute stage stalls on `busy` and writes `result` back on `done`.

## Interface
- `XLEN`, 32: operand and result width; must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only when idle.
- `op`  in  3  RV32M funct3:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  XLEN  rs1 operand.
- `b`  in  XLEN  rs2 operand.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  XLEN  registered result; held until the next accepted start.
- `illegal`  out  1  pulses with `done` when `op` is unsupported in this build.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + `start`=1 at an edge:
  - capture `op`.
  - capture |a| and |b| (the absolute value only where the op treats that operand as signed).
  - record the result sign.
  - counter ← XLEN.
  - go to CALC.
- CALC: one iteration per edge; counter decrements; when the counter reaches 0, go to FIX.
  - Multiply: shift-add into a 2·XLEN product.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- FIX: one edge, then IDLE with `done`=1 for that one cycle.
  - Apply two's-complement sign correction.
  - Select the low or high product half, or the quotient or remainder.
  - Write `result`.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: `a` signed, `b` unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: sign-agnostic low half.
  - REM: the remainder takes the sign of the dividend.
- Special cases are resolved in FIX with the same latency; they do not take an early exit.
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → `a`.
  - Signed overflow (a = −2^(XLEN−1), b = −1): DIV → `a`; REM → 0.
- `start` while `busy`=1 is ignored. Operand changes after capture have no effect.
- `start` in the cycle where `done`=1 (state IDLE) is accepted.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `illegal`=0, state IDLE.
- Edge E0 accepts `start`. `busy`=1 from after E0 through E(XLEN+1).
- `done`=1 and `result` valid in the cycle after E(XLEN+1), and `busy`=0 in that same cycle. Latency is XLEN+1 edges (33 for XLEN=32), identical for every op.
- `busy` and `done` are never high together. `done` is exactly one cycle.
- `rst` mid-operation aborts immediately: all outputs and state return to reset values and no `done` is produced. The first `start` after deassertion behaves as from fresh reset.

## Configuration
- Macro: `MULDIV_DIV_EN`.
- Defined: full M-extension. `illegal` is constant 0.
- Undefined:
  - Divider datapath and remainder logic are not built.
  - MUL/MULH/MULHSU/MULHU behave as above.
  - Ops 100–111 are accepted, take a 1-edge path: `busy` for one cycle, then `done`=1, `illegal`=1, `result`=0.

## Test plan
All scenarios use XLEN=32.
- MUL a=7, b=0xFFFFFFFD (−3) → `result`=0xFFFFFFEB, `done` exactly 33 edges after start, `busy` high 33 cycles.
- High-half products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide and remainder (with the divider built):
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
  - 1000 random operand pairs per op, checked against a reference model.
- Corner cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Handshake:
  - `start` pulsed with new operands at cycle 10 of a busy operation → ignored, first result unchanged.
  - `start` in the `done` cycle → accepted, second `done` 33 edges later.
  - `rst` at cycle 15 → `busy`=0, `result`=0, no `done` pulse.
- Build without `MULDIV_DIV_EN`:
  - DIV 9/3 → `done` after 1 edge, `illegal`=1, `result`=0.
  - MUL 6×7 → 42 with `illegal`=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with a start/busy/done handshake.
// Build option: define MULDIV_DIV_EN to include the divider (DIV/DIVU/REM/REMU).
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand conditioning at capture time
  logic            a_signed, b_signed, a_neg, b_neg, start_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    // A zero divisor leaves the quotient all ones; keeping it unsigned yields -1 for DIV.
    if (!op[2])     start_neg = a_neg ^ b_neg;
    else if (op[1]) start_neg = a_neg;
    else            start_neg = (a_neg ^ b_neg) & (|b);
  end

  // Multiply step: acc holds {partial product, remaining multiplier bits}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_fix;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    prod_fix = neg_q ? -acc_q : acc_q;
  end

`ifdef MULDIV_DIV_EN
  // Restoring divide step: acc holds {remainder, dividend/quotient}
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!div_diff[XLEN]) div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else                 div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    quo_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          opnd_d = b_mag;
          acc_d  = {{XLEN{1'b0}}, a_mag};
          neg_d  = start_neg;
          cnt_d  = CW'(XLEN);
          busy_d = 1'b1;
`ifdef MULDIV_DIV_EN
          state_d = S_CALC;
`else
          state_d = op[2] ? S_FIX : S_CALC;
`endif
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
`ifdef MULDIV_DIV_EN
        acc_d = op_q[2] ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!op_q[2]) begin
          result_d = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
`ifdef MULDIV_DIV_EN
          result_d = op_q[1] ? rem_fix : quo_fix;
`else
          result_d  = '0;
          illegal_d = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign illegal = illegal_q;

endmodule
